// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and lane helpers for the multi-cycle data memory controller.
// Optional per-byte parity is enabled with the DMEM_PARITY_EN macro.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Lane k is byte address base+k and occupies bits [31-8k -: 8] of a packed lane word.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[0];
      SZ_WORD: err = (lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {wdata[7:0], 24'h000000};
      SZ_HALF: lanes = {wdata[15:0], 16'h0000};
      SZ_WORD: lanes = wdata;
      default: lanes = 32'h0000_0000;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sext,
                                         input logic [31:0] lanes);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {{24{sext & lanes[31]}}, lanes[31:24]};
      SZ_HALF: res = {{16{sext & lanes[31]}}, lanes[31:16]};
      SZ_WORD: res = lanes;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM-stage control FSM (master) and dmem_ctrl (slave).
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              Req;
  logic              WE;
  logic [1:0]        Size;
  logic              SignExt;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       WData;
  logic              Ready;
  logic              Busy;
  logic              Valid;
  logic [31:0]       RData;
  logic              AlignErr;
  logic              ParErr;

  modport master (
    output Req, WE, Size, SignExt, Addr, WData,
    input  Ready, Busy, Valid, RData, AlignErr, ParErr
  );

  modport slave (
    input  Req, WE, Size, SignExt, Addr, WData,
    output Ready, Busy, Valid, RData, AlignErr, ParErr
  );
endinterface

// File: rtl/dmem_byte_array.sv
// Byte-organised storage with four lane write enables and a registered 4-byte read.
// Under DMEM_PARITY_EN an even-parity bit is kept per byte and checked on reads.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 128,
  parameter int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] base,
  input  logic [3:0]       wr_mask,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [3:0]       rd_mask,
  output logic [31:0]      rd_data,
  output logic             par_err
);

  logic [7:0]       mem_q [DEPTH_BYTES];
  logic [IDX_W-1:0] lane_idx_s [4];
  logic [31:0]      rd_d;
  logic [31:0]      rd_q;

  // Lane addresses wrap naturally modulo the power-of-two depth.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_idx_s[k] = base + IDX_W'(k);
    end
  end

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_mask[k]) begin
        mem_q[lane_idx_s[k]] <= wr_data[31-8*k -: 8];
      end
    end
  end

  // Read data next value.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      for (int k = 0; k < 4; k++) begin
        rd_d[31-8*k -: 8] = mem_q[lane_idx_s[k]];
      end
    end else begin
      rd_d = rd_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 32'h0000_0000;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data = rd_q;

`ifdef DMEM_PARITY_EN
  logic par_mem_q [DEPTH_BYTES];
  logic par_d;
  logic par_q;

  // Parity bits follow their data bytes and are not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_mask[k]) begin
        par_mem_q[lane_idx_s[k]] <= ^wr_data[31-8*k -: 8];
      end
    end
  end

  // Only the lanes the access actually touches may raise a parity error.
  always_comb begin
    par_d = par_q;
    if (rd_en) begin
      par_d = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (rd_mask[k] && ((^mem_q[lane_idx_s[k]]) != par_mem_q[lane_idx_s[k]])) begin
          par_d = 1'b1;
        end
      end
    end else begin
      par_d = par_q;
    end
  end

  // Parity error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign par_err = par_q;
`else
  logic unused_rd_mask_s;
  assign unused_rd_mask_s = ^rd_mask;
  assign par_err          = 1'b0;
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory controller: handshake FSM, latency counter, alignment check,
// big-endian lane steering and read extension. Parity option: DMEM_PARITY_EN.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  dmem_ctrl_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       rsize_q, rsize_d;
  logic             rsext_q, rsext_d;
  logic             err_q, err_d;
  logic             rd_done_q, rd_done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic             acc_s;
  logic             commit_s;
  logic             cur_we_s;
  logic [1:0]       cur_size_s;
  logic             cur_sext_s;
  logic [IDX_W-1:0] cur_idx_s;
  logic [31:0]      cur_wdata_s;
  logic             cur_err_s;
  logic [3:0]       wr_mask_s;
  logic             rd_en_s;
  logic [31:0]      rd_data_s;
  logic             par_err_s;
  logic             unused_addr_s;

  assign unused_addr_s = ^bus.Addr[ADDR_W-1:IDX_W];

  // The array is touched on the edge entering RESP; with a single-cycle latency that
  // edge is the acceptance edge itself, so the access comes straight from the bus.
  always_comb begin
    acc_s = bus.Req & ready_q;
    if (LATENCY == 1) begin
      commit_s    = acc_s & ~Reset;
      cur_we_s    = bus.WE;
      cur_size_s  = bus.Size;
      cur_sext_s  = bus.SignExt;
      cur_idx_s   = bus.Addr[IDX_W-1:0];
      cur_wdata_s = bus.WData;
    end else begin
      commit_s    = (state_q == WAIT) && (cnt_q == CNT_W'(1)) && !Reset;
      cur_we_s    = we_q;
      cur_size_s  = size_q;
      cur_sext_s  = sext_q;
      cur_idx_s   = idx_q;
      cur_wdata_s = wdata_q;
    end
    cur_err_s = align_err(cur_size_s, cur_idx_s[1:0]);
    wr_mask_s = (commit_s && cur_we_s && !cur_err_s) ? lane_mask(cur_size_s) : 4'b0000;
    rd_en_s   = commit_s && !cur_we_s && !cur_err_s;
  end

  // Next-state, capture and response-format logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    sext_d    = sext_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rsize_d   = rsize_q;
    rsext_d   = rsext_q;
    err_d     = err_q;
    rd_done_d = rd_done_q;
    case (state_q)
      IDLE, RESP: begin
        if (acc_s) begin
          we_d    = bus.WE;
          size_d  = bus.Size;
          sext_d  = bus.SignExt;
          idx_d   = bus.Addr[IDX_W-1:0];
          wdata_d = bus.WData;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // Format registers change only on a completed read so RData holds between reads.
    if (commit_s) begin
      err_d     = cur_err_s;
      rd_done_d = rd_en_s;
      if (rd_en_s) begin
        rsize_d = cur_size_s;
        rsext_d = cur_sext_s;
      end else begin
        rsize_d = rsize_q;
        rsext_d = rsext_q;
      end
    end else begin
      err_d     = err_q;
      rd_done_d = rd_done_q;
    end
    ready_d = (state_d != WAIT);
    busy_d  = (state_d == WAIT);
    valid_d = (state_d == RESP);
  end

  // Controller state and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      sext_q    <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'h0000_0000;
      rsize_q   <= SZ_BYTE;
      rsext_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_done_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      size_q    <= size_d;
      sext_q    <= sext_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rsize_q   <= rsize_d;
      rsext_q   <= rsext_d;
      err_q     <= err_d;
      rd_done_q <= rd_done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  dmem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .IDX_W       (IDX_W)
  ) u_arr (
    .clk     (CLK),
    .rst     (Reset),
    .base    (cur_idx_s),
    .wr_mask (wr_mask_s),
    .wr_data (steer_wdata(cur_size_s, cur_wdata_s)),
    .rd_en   (rd_en_s),
    .rd_mask (lane_mask(cur_size_s)),
    .rd_data (rd_data_s),
    .par_err (par_err_s)
  );

  // RData and the error flags are pure functions of registers, never of bus inputs.
  assign bus.Ready    = ready_q;
  assign bus.Busy     = busy_q;
  assign bus.Valid    = valid_q;
  assign bus.RData    = err_q ? 32'h0000_0000 : extend(rsize_q, rsext_q, rd_data_s);
  assign bus.AlignErr = err_q;
`ifdef DMEM_PARITY_EN
  assign bus.ParErr   = par_err_s & rd_done_q & ~err_q;
`else
  logic unused_par_s;
  assign unused_par_s = par_err_s ^ rd_done_q;
  assign bus.ParErr   = 1'b0;
`endif

endmodule
